time_unit_counter: RTL and testbench

Parametrised modulo-N time-field counter for the clock datapath, used for seconds, minutes and hours stages. It counts synchronous enable ticks up or down, supports a direct set (load), and emits one-cycle wrap pulses for chaining. It also provides registered two-digit BCD display outputs with an optional 12-hour presentation. Stages are cascaded by wiring one stage's carry/borrow into the next stage's tick; every stage runs on the single system clock.

---
 rtl/time_unit_counter_if.sv | 28 ++
 rtl/time_unit_counter.sv | 104 ++++++++++
 tb/tb_time_unit_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/time_unit_counter_if.sv
// Control and display bundle for one time-field counter stage.
// The master side drives count/load requests and the slave side returns count, wrap and display state.
interface time_unit_counter_if #(
  parameter int WIDTH = 5
) ();
  logic             tick;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode_12h;
  logic [WIDTH-1:0] value;
  logic             carry;
  logic             borrow;
  logic             load_err;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             pm;

  modport master (
    output tick, down, load, load_val, mode_12h,
    input  value, carry, borrow, load_err, tens, ones, pm
  );

  modport slave (
    input  tick, down, load, load_val, mode_12h,
    output value, carry, borrow, load_err, tens, ones, pm
  );
endinterface

// File: rtl/time_unit_counter.sv
// Modulo-MODULUS up/down time-field counter with load, wrap pulses for cascading,
// and a registered BCD display that trails the count by one cycle.
module time_unit_counter #(
  parameter int MODULUS = 24,
  parameter int WIDTH   = 5,
  parameter int HAS_12H = 1
) (
  input logic               clk,
  input logic               reset,
  time_unit_counter_if.slave bus
);

  localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam bit               USE_12H = (HAS_12H != 0) && (MODULUS == 24);

  logic [WIDTH-1:0] value_p0;
  logic             carry_p0;
  logic             borrow_p0;
  logic             load_err_p0;
  logic [3:0]       tens_p1;
  logic [3:0]       ones_p1;
  logic             pm_p1;

  function automatic logic in_range(input logic [WIDTH-1:0] v);
    return {1'b0, v} < MOD_X;
  endfunction

  // Returns {pm, tens, ones}; in 12h presentation hour 0/12 reads as 12.
  function automatic logic [8:0] disp_f(input logic [WIDTH-1:0] v, input logic h12);
    int unsigned n;
    logic        p;
    n = 32'(v);
    p = 1'b0;
    if (h12) begin
      p = (n >= 12);
      if (p) n = n - 12;
      if (n == 0) n = 12;
    end
    return {p, 4'(n / 10), 4'(n % 10)};
  endfunction

  // Stage p0: count register and wrap/error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_p0    <= '0;
      carry_p0    <= 1'b0;
      borrow_p0   <= 1'b0;
      load_err_p0 <= 1'b0;
    end else begin
      carry_p0    <= 1'b0;
      borrow_p0   <= 1'b0;
      load_err_p0 <= 1'b0;
      if (bus.load) begin
        if (in_range(bus.load_val)) begin
          value_p0 <= bus.load_val;
        end else begin
          load_err_p0 <= 1'b1;
          if (!in_range(value_p0)) value_p0 <= '0;
        end
      end else if (bus.tick) begin
        if (!bus.down) begin
          if (value_p0 == TOP) begin
            value_p0 <= '0;
            carry_p0 <= 1'b1;
          end else if (!in_range(value_p0)) begin
            value_p0 <= '0;
          end else begin
            value_p0 <= value_p0 + 1'b1;
          end
        end else begin
          if (value_p0 == '0) begin
            value_p0  <= TOP;
            borrow_p0 <= 1'b1;
          end else if (!in_range(value_p0)) begin
            value_p0 <= TOP;
          end else begin
            value_p0 <= value_p0 - 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: display digits derived from the registered count
  always_ff @(posedge clk) begin
    if (!reset) begin
      tens_p1 <= 4'd0;
      ones_p1 <= 4'd0;
      pm_p1   <= 1'b0;
    end else begin
      {pm_p1, tens_p1, ones_p1} <= disp_f(value_p0, USE_12H && bus.mode_12h);
    end
  end

  assign bus.value    = value_p0;
  assign bus.carry    = carry_p0;
  assign bus.borrow   = borrow_p0;
  assign bus.load_err = load_err_p0;
  assign bus.tens     = tens_p1;
  assign bus.ones     = ones_p1;
  assign bus.pm       = pm_p1;

endmodule

// File: tb/tb_time_unit_counter.sv
// Bench for time_unit_counter: a MODULUS=24 (12h capable) and a MODULUS=60 instance
// driven in lockstep and compared against a modular-arithmetic reference model.
module tb_time_unit_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_unit_counter_if #(.WIDTH(5)) if24 ();
  time_unit_counter_if #(.WIDTH(6)) if60 ();

  time_unit_counter #(.MODULUS(24), .WIDTH(5), .HAS_12H(1)) u24 (
    .clk(clk), .reset(reset), .bus(if24.slave));
  time_unit_counter #(.MODULUS(60), .WIDTH(6), .HAS_12H(1)) u60 (
    .clk(clk), .reset(reset), .bus(if60.slave));

  int checks   = 0;
  int failures = 0;

  int M [2] = '{24, 60};
  bit H [2] = '{1'b1, 1'b0};
  int mv[2], mc[2], mb[2], me[2], dt[2], dn_[2], dp[2];

  typedef struct {
    bit rst_n; bit ld; int lv; bit tk; bit dn; bit md;
    int ev; int ec; int eb; int ee;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_edge(input int i, input bit rst_n, input bit ld, input int lv,
                            input bit tk, input bit dn, input bit md);
    int h;
    if (!rst_n) begin
      mv[i] = 0; mc[i] = 0; mb[i] = 0; me[i] = 0; dt[i] = 0; dn_[i] = 0; dp[i] = 0;
      return;
    end
    if (H[i] && md) begin
      dp[i] = mv[i] / 12;
      h = mv[i] % 12;
      if (h == 0) h = 12;
      dt[i] = h / 10; dn_[i] = h % 10;
    end else begin
      dp[i] = 0; dt[i] = mv[i] / 10; dn_[i] = mv[i] % 10;
    end
    mc[i] = 0; mb[i] = 0; me[i] = 0;
    if (ld) begin
      if (lv < M[i]) mv[i] = lv;
      else me[i] = 1;
    end else if (tk) begin
      if (!dn) begin
        mv[i] = (mv[i] + 1) % M[i];
        mc[i] = (mv[i] == 0);
      end else begin
        mb[i] = (mv[i] == 0);
        mv[i] = (mv[i] + M[i] - 1) % M[i];
      end
    end
  endtask

  task automatic step(input bit rst_n, input bit ld, input int lv,
                      input bit tk, input bit dn, input bit md);
    reset = rst_n;
    if24.load = ld; if24.load_val = 5'(lv); if24.tick = tk; if24.down = dn; if24.mode_12h = md;
    if60.load = ld; if60.load_val = 6'(lv); if60.tick = tk; if60.down = dn; if60.mode_12h = md;
    model_edge(0, rst_n, ld, lv % 32, tk, dn, md);
    model_edge(1, rst_n, ld, lv % 64, tk, dn, md);
    @(posedge clk);
    #1;
    chk("u24 value", if24.value, mv[0]);
    chk("u24 carry", if24.carry, mc[0]);
    chk("u24 borrow", if24.borrow, mb[0]);
    chk("u24 load_err", if24.load_err, me[0]);
    chk("u24 tens", if24.tens, dt[0]);
    chk("u24 ones", if24.ones, dn_[0]);
    chk("u24 pm", if24.pm, dp[0]);
    chk("u60 value", if60.value, mv[1]);
    chk("u60 carry", if60.carry, mc[1]);
    chk("u60 borrow", if60.borrow, mb[1]);
    chk("u60 load_err", if60.load_err, me[1]);
    chk("u60 tens", if60.tens, dt[1]);
    chk("u60 ones", if60.ones, dn_[1]);
    chk("u60 pm", if60.pm, dp[1]);
  endtask

  initial begin
    int exp12 [4][4];
    reset = 1'b0;
    if24.load = 0; if24.load_val = '0; if24.tick = 0; if24.down = 0; if24.mode_12h = 0;
    if60.load = 0; if60.load_val = '0; if60.tick = 0; if60.down = 0; if60.mode_12h = 0;

    //            rst ld lv  tk dn md   ev ec eb ee
    vt[0]  = '{0, 0, 0,  0, 0, 0,  0, 0, 0, 0};
    vt[1]  = '{1, 1, 0,  0, 0, 0,  0, 0, 0, 0};
    vt[2]  = '{1, 0, 0,  1, 1, 0, 23, 0, 1, 0};
    vt[3]  = '{1, 0, 0,  1, 1, 0, 22, 0, 0, 0};
    vt[4]  = '{1, 0, 0,  1, 1, 0, 21, 0, 0, 0};
    vt[5]  = '{1, 0, 0,  1, 1, 0, 20, 0, 0, 0};
    vt[6]  = '{1, 1, 5,  0, 0, 0,  5, 0, 0, 0};
    vt[7]  = '{1, 1, 30, 1, 0, 0,  5, 0, 0, 1};
    vt[8]  = '{1, 1, 17, 1, 0, 0, 17, 0, 0, 0};
    vt[9]  = '{1, 1, 23, 0, 0, 0, 23, 0, 0, 0};
    vt[10] = '{0, 0, 0,  1, 0, 0,  0, 0, 0, 0};
    vt[11] = '{1, 1, 22, 0, 0, 1, 22, 0, 0, 0};
    vt[12] = '{1, 0, 0,  1, 0, 1, 23, 0, 0, 0};
    vt[13] = '{1, 0, 0,  1, 0, 1,  0, 1, 0, 0};
    vt[14] = '{1, 0, 0,  1, 0, 0,  1, 0, 0, 0};
    vt[15] = '{1, 0, 0,  1, 1, 0,  0, 0, 0, 0};
    vt[16] = '{1, 0, 0,  1, 1, 0, 23, 0, 1, 0};

    for (int k = 0; k < 17; k++) begin
      step(vt[k].rst_n, vt[k].ld, vt[k].lv, vt[k].tk, vt[k].dn, vt[k].md);
      chk($sformatf("vec%0d value", k), if24.value, vt[k].ev);
      chk($sformatf("vec%0d carry", k), if24.carry, vt[k].ec);
      chk($sformatf("vec%0d borrow", k), if24.borrow, vt[k].eb);
      chk($sformatf("vec%0d load_err", k), if24.load_err, vt[k].ee);
    end

    // Full up-count cycle from reset, display trailing by one cycle
    step(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      step(1, 0, 0, 1, 0, 0);
      chk($sformatf("up%0d value", k), if24.value, k % 24);
      chk($sformatf("up%0d carry", k), if24.carry, (k == 24));
    end
    chk("up wrap tens", if24.tens, 2);
    chk("up wrap ones", if24.ones, 3);
    step(1, 0, 0, 0, 0, 0);
    chk("up post tens", if24.tens, 0);
    chk("up post ones", if24.ones, 0);
    chk("up post carry", if24.carry, 0);

    // 12h presentation, including first display after reset
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("12h rst tens", if24.tens, 1);
    chk("12h rst ones", if24.ones, 2);
    chk("12h rst pm", if24.pm, 0);
    exp12[0] = '{0, 1, 2, 0};
    exp12[1] = '{12, 1, 2, 1};
    exp12[2] = '{13, 0, 1, 1};
    exp12[3] = '{23, 1, 1, 1};
    for (int k = 0; k < 4; k++) begin
      step(1, 1, exp12[k][0], 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      chk($sformatf("12h v%0d tens", exp12[k][0]), if24.tens, exp12[k][1]);
      chk($sformatf("12h v%0d ones", exp12[k][0]), if24.ones, exp12[k][2]);
      chk($sformatf("12h v%0d pm", exp12[k][0]), if24.pm, exp12[k][3]);
    end

    // MODULUS=60 wrap with 12h requested (must not affect display)
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 59; k++) step(1, 0, 0, 1, 0, 1);
    chk("m60 pre value", if60.value, 59);
    step(1, 0, 0, 1, 0, 1);
    chk("m60 wrap value", if60.value, 0);
    chk("m60 wrap carry", if60.carry, 1);
    chk("m60 wrap tens", if60.tens, 5);
    chk("m60 wrap ones", if60.ones, 9);
    chk("m60 wrap pm", if60.pm, 0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 63)),
           ($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, 1));
      chk("excl pulses 24", {31'b0, (if24.carry + if24.borrow + if24.load_err) > 1}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
